// File: rtl/block_buffer_mem.sv
// Block buffer memory: accepts whole BLK_DIM x BLK_DIM blocks in a single edge.
// Blocks are stored sequentially until a frame of NUM_BLKS blocks is complete.
// The frame is then held until a release pulse restarts the fill.
// The buffer provides a 1-cycle-latency registered read port with read-before-write semantics.
//
// Optional feature: define BLOCK_BUFFER_ZERO_INIT_EN to have reset asynchronously clear
// every storage word. Without it the storage has no reset, which keeps it RAM-inferable.
//
// The frame-release pulse is named frame_release because 'release' is a reserved word.

module block_buffer_mem #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned BLK_DIM   = 8,
   parameter int unsigned NUM_BLKS  = 32,
   parameter int unsigned TRANSPOSE = 0,
   localparam int unsigned ADDR_W   = $clog2(NUM_BLKS * BLK_DIM * BLK_DIM),
   localparam int unsigned CNT_W    = $clog2(NUM_BLKS + 1)
) (
   input  logic                                     clock,
   input  logic                                     reset,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic [BLK_DIM-1:0][BLK_DIM-1:0][DATA_W-1:0] in_block,
   input  logic                                     frame_release,
   input  logic                                     rd_en,
   input  logic [ADDR_W-1:0]                        rd_addr,
   output logic [DATA_W-1:0]                        rd_data,
   output logic [CNT_W-1:0]                         blk_count,
   output logic                                     full,
   output logic                                     frame_done
);

   // Offset of a sample inside its block; BLK_DIM is a power of two, so the block
   // number simply forms the upper address bits.
   localparam int unsigned OFF_W = $clog2(BLK_DIM * BLK_DIM);
   localparam int unsigned BLK_W = ADDR_W - OFF_W;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_FULL = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [BLK_W-1:0]  wr_blk_q, wr_blk_d;
   logic [CNT_W-1:0]  blk_count_q, blk_count_d;
   logic              frame_done_q, frame_done_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              wr_en;

   logic [DATA_W-1:0] mem [DEPTH];

   function automatic logic [OFF_W-1:0] sample_off(input int unsigned r, input int unsigned c);
      if (TRANSPOSE != 0) begin
         return OFF_W'(c * BLK_DIM + r);
      end
      return OFF_W'(r * BLK_DIM + c);
   endfunction

   assign wr_en = in_valid && (state_q == ST_FILL);

   // Fill/full sequencing, write-block pointer and frame_done pulse.
   always_comb begin
      state_d      = state_q;
      wr_blk_d     = wr_blk_q;
      blk_count_d  = blk_count_q;
      frame_done_d = 1'b0;
      case (state_q)
         ST_FILL: begin
            if (wr_en) begin
               wr_blk_d    = wr_blk_q + 1'b1;
               blk_count_d = blk_count_q + 1'b1;
               if (blk_count_q == CNT_W'(NUM_BLKS - 1)) begin
                  state_d      = ST_FULL;
                  frame_done_d = 1'b1;
               end
            end
         end
         ST_FULL: begin
            // Release only matters once the frame is complete; in FILL it is ignored.
            if (frame_release) begin
               state_d     = ST_FILL;
               blk_count_d = '0;
               wr_blk_d    = '0;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   // Registered read; holds its value when no read is requested.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem[rd_addr];
      end
   end

   // Control and read-data state, asynchronously reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_FILL;
         wr_blk_q     <= '0;
         blk_count_q  <= '0;
         frame_done_q <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         wr_blk_q     <= wr_blk_d;
         blk_count_q  <= blk_count_d;
         frame_done_q <= frame_done_d;
         rd_data_q    <= rd_data_d;
      end
   end

`ifdef BLOCK_BUFFER_ZERO_INIT_EN
   // Storage write of a whole block per transfer; reset clears every word.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[ADDR_W'(i)] <= '0;
         end
      end else if (wr_en) begin
         for (int unsigned r = 0; r < BLK_DIM; r++) begin
            for (int unsigned c = 0; c < BLK_DIM; c++) begin
               mem[{wr_blk_q, sample_off(r, c)}] <= in_block[r][c];
            end
         end
      end
   end
`else
   // Storage write of a whole block per transfer; no reset so it maps onto RAM.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int unsigned r = 0; r < BLK_DIM; r++) begin
            for (int unsigned c = 0; c < BLK_DIM; c++) begin
               mem[{wr_blk_q, sample_off(r, c)}] <= in_block[r][c];
            end
         end
      end
   end
`endif

   assign in_ready   = (state_q == ST_FILL);
   assign full       = (state_q == ST_FULL);
   assign blk_count  = blk_count_q;
   assign frame_done = frame_done_q;
   assign rd_data    = rd_data_q;

endmodule
